ps2_rx: RTL and testbench

- Receives PS/2 device-to-host frames on the keyboard or mouse pins (mprj_io[8..11] pairs) and delivers bytes to the input decoder via a valid/ready handshake.
- Sits directly upstream of the wiggly_ic_1 input logic.
- Instantiated twice: once for the keyboard, once for the mouse.
- Host-to-device transmission is out of scope. The block never drives the PS/2 lines.

---
 rtl/ps2_rx.sv | 184 ++++++++++++++++++
 tb/tb_ps2_rx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// ps2_rx -- PS/2 device-to-host frame receiver with a one-entry output buffer.
//
// Both raw pins are synchronized and glitch-filtered. Each falling edge of
// the filtered clock advances the frame FSM, which samples the filtered data
// line. Good frames are offered to the consumer over a valid/ready handshake.
// The block only listens and never drives the PS/2 lines.
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   resetb     synchronous active-low reset
//   ps2_clk    raw PS/2 clock pin (asynchronous to clk)
//   ps2_data   raw PS/2 data pin (asynchronous to clk)
//   rx_data    received byte (LSB first on the wire)
//   rx_valid   rx_data holds an unconsumed byte
//   rx_ready   consumer takes rx_data when rx_valid && rx_ready
//   parity_err 1-cycle pulse: frame dropped for bad odd parity
//   frame_err  1-cycle pulse: bad start/stop bit, or mid-frame timeout
//   overflow   1-cycle pulse: good frame dropped because the buffer was full
module ps2_rx #(
  parameter int FILTER_LEN     = 8,      // 2..255
  parameter int TIMEOUT_CYCLES = 20000   // 16..2^20
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);

  localparam int FC_W = $clog2(FILTER_LEN);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [FC_W-1:0] FILT_LAST = FC_W'(FILTER_LEN - 1);
  // to_cnt holds (cycles since the last fall) - 1, so the expiry compare
  // sits one below the last count and the registered frame_err pulse lands
  // exactly TIMEOUT_CYCLES cycles after that fall.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Index 1 is the PS/2 clock line, index 0 the PS/2 data line.
  logic [1:0]      pins;
  logic [1:0]      sync1, sync2, level;
  logic [FC_W-1:0] fcnt [2];
  logic            fall;
  logic            data_f;

  state_t          state, state_n;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_bit;
  logic [TO_W-1:0] to_cnt;
  logic            good, perr, ferr, tmo;

  assign pins   = {ps2_clk, ps2_data};
  assign data_f = level[0];

  // Input conditioning: 2-FF synchronizer, then a level filter that only
  // follows the pin after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!resetb) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      level   <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
      fall    <= 1'b0;
    end else begin
      sync1 <= pins;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FILT_LAST) begin
          fcnt[i]  <= '0;
          level[i] <= sync2[i];
        end else begin
          fcnt[i] <= fcnt[i] + FC_W'(1);
        end
      end
      // Strobe in the same cycle the filtered clock drops to 0.
      fall <= level[1] && !sync2[1] && (fcnt[1] == FILT_LAST);
    end
  end

  // Next-state and frame verdict.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    state_n = state;
    good    = 1'b0;
    perr    = 1'b0;
    ferr    = 1'b0;
    tmo     = (state != IDLE) && !fall && (to_cnt == TO_LAST);
    case (state)
      IDLE: begin
        if (fall) begin
          if (!data_f) state_n = DATA;
          else         ferr    = 1'b1;
        end
      end
      DATA: begin
        if (fall && bit_cnt == 3'd7) state_n = PARITY;
      end
      PARITY: begin
        if (fall) state_n = STOP;
      end
      STOP: begin
        if (fall) begin
          state_n = IDLE;
          // Framing wins over parity.
          if (!data_f)                 ferr = 1'b1;
          else if (^{shreg, par_bit})  good = 1'b1;
          else                         perr = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (tmo) begin
      state_n = IDLE;
      ferr    = 1'b1;
    end
  end

  // State, datapath, output buffer and pulses.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      // NOTE: the shift register is plain flops, so clearing it on reset
      // is cheap and keeps a discarded partial frame from ever resurfacing.
      shreg      <= '0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state <= state_n;

      if (state == IDLE || fall) to_cnt <= '0;
      else                       to_cnt <= to_cnt + TO_W'(1);

      if (fall) begin
        case (state)
          IDLE: begin
            bit_cnt <= '0;
            shreg   <= '0;
          end
          DATA: begin
            shreg[bit_cnt] <= data_f;
            bit_cnt        <= bit_cnt + 3'd1;
          end
          PARITY:  par_bit <= data_f;
          default: ;
        endcase
      end

      parity_err <= perr;
      frame_err  <= ferr;
      overflow   <= 1'b0;

      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      // A same-cycle handshake frees the slot, so the new byte still loads.
      if (good) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx -- directed bench for ps2_rx: FILTER_LEN=4, TIMEOUT_CYCLES=200,
// PS/2 bit period 40 clk. Expected bytes go into a queue when a frame is
// sent and are compared when the DUT hands them over.
module tb_ps2_rx;

  localparam int FL   = 4;
  localparam int TO   = 200;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overflow;

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .resetb     (resetb),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int valid_cyc, ovf_cnt, perr_cnt, ferr_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled on the falling clk edge, away from DUT updates.
  always @(negedge clk) begin
    if (rx_valid)   valid_cyc++;
    if (overflow)   ovf_cnt++;
    if (parity_err) perr_cnt++;
    if (frame_err)  ferr_cnt++;
    if (resetb && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) check("unexpected_byte", {24'h0, rx_data}, 32'hFFFF_FFFF);
      else                   check("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
    end
  end

  // Inputs change 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_counts();
    valid_cyc = 0;
    ovf_cnt   = 0;
    perr_cnt  = 0;
    ferr_cnt  = 0;
  endtask

  // Sends the first nfalls bits of a frame. With hook set, rx_ready is raised
  // for exactly the cycle in which the DUT completes the stop bit.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop_bit,
                            input int nfalls, input bit hook, output int last_c);
    logic [10:0] bits;
    bits   = {stop_bit, (~^b) ^ bad_par, b, 1'b0};
    last_c = 0;
    for (int k = 0; k < nfalls; k++) begin
      ps2_data = bits[k];
      step(HALF / 2);
      ps2_clk = 1'b0;
      last_c  = cyc;
      for (int i = 0; i < HALF; i++) begin
        if (hook && k == 10 && i == 2 + FL) rx_ready = 1'b1;
        if (hook && k == 10 && i == 3 + FL) rx_ready = 1'b0;
        step(1);
      end
      ps2_clk = 1'b1;
      step(HALF / 2);
    end
    ps2_data = 1'b1;
    step(HALF);
  endtask

  initial begin
    int lc;
    int hit;
    bit found;

    // Reset state
    rx_ready = 1'b1;
    resetb   = 1'b0;
    step(3);
    check("rst_rx_valid", {31'h0, rx_valid}, 0);
    check("rst_rx_data", {24'h0, rx_data}, 0);
    check("rst_pulses", {29'h0, parity_err, frame_err, overflow}, 0);
    resetb = 1'b1;
    step(5);

    // Good frame 0x1C
    clear_counts();
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, lc);
    step(5);
    check("good_q_empty", exp_q.size(), 0);
    check("good_valid_cycles", valid_cyc, 1);
    check("good_no_err", ovf_cnt + perr_cnt + ferr_cnt, 0);

    // Back-pressure and overflow
    clear_counts();
    rx_ready = 1'b0;
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0, lc);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, lc);
    step(5);
    check("bp_rx_valid", {31'h0, rx_valid}, 1);
    check("bp_rx_data", {24'h0, rx_data}, 32'hF0);
    check("bp_overflow_cnt", ovf_cnt, 1);
    rx_ready = 1'b1;
    step(1);
    check("bp_valid_cleared", {31'h0, rx_valid}, 0);
    check("bp_q_empty", exp_q.size(), 0);

    // Parity error
    clear_counts();
    send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0, lc);
    step(5);
    check("par_perr_cnt", perr_cnt, 1);
    check("par_other", ferr_cnt + ovf_cnt + valid_cyc, 0);

    // Bad stop bit
    clear_counts();
    send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0, lc);
    step(5);
    check("stop_ferr_cnt", ferr_cnt, 1);
    check("stop_other", perr_cnt + ovf_cnt + valid_cyc, 0);

    // Short glitch on ps2_clk while idle: a fall here would give frame_err
    clear_counts();
    ps2_clk = 1'b0;
    step(2);
    ps2_clk = 1'b1;
    step(30);
    check("glitch_no_pulse", ferr_cnt + perr_cnt + valid_cyc, 0);

    // Timeout after 5 data bits
    clear_counts();
    send_frame(8'h1C, 1'b0, 1'b1, 6, 1'b0, lc);
    found = 1'b0;
    hit   = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (frame_err) begin
        found = 1'b1;
        hit   = cyc;
      end
    end
    step(5);
    check("tmo_seen", {31'h0, found}, 1);
    // fall lags the pin drive by 2+FL cycles, then TO cycles to the pulse.
    check("tmo_latency", hit - lc, 2 + FL + TO);
    check("tmo_ferr_cnt", ferr_cnt, 1);
    check("tmo_no_valid", valid_cyc, 0);

    clear_counts();
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b0, 1'b1, 11, 1'b0, lc);
    step(5);
    check("after_tmo_q_empty", exp_q.size(), 0);
    check("after_tmo_valid", valid_cyc, 1);
    check("after_tmo_no_err", ovf_cnt + perr_cnt + ferr_cnt, 0);

    // Reset mid-DATA
    clear_counts();
    send_frame(8'hAA, 1'b0, 1'b1, 4, 1'b0, lc);
    resetb = 1'b0;
    step(1);
    resetb = 1'b1;
    check("mid_rst_outputs", {rx_data, rx_valid, parity_err, frame_err, overflow}, 0);
    step(2 * TO + 20);
    check("mid_rst_silent", ferr_cnt + perr_cnt + ovf_cnt + valid_cyc, 0);
    clear_counts();
    exp_q.push_back(8'hAA);
    send_frame(8'hAA, 1'b0, 1'b1, 11, 1'b0, lc);
    step(5);
    check("post_rst_q_empty", exp_q.size(), 0);
    check("post_rst_valid", valid_cyc, 1);

    // Completion coincident with the handshake of the previous byte
    clear_counts();
    rx_ready = 1'b0;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    send_frame(8'h12, 1'b0, 1'b1, 11, 1'b0, lc);
    send_frame(8'h34, 1'b0, 1'b1, 11, 1'b1, lc);
    check("coin_rx_valid", {31'h0, rx_valid}, 1);
    check("coin_rx_data", {24'h0, rx_data}, 32'h34);
    check("coin_no_overflow", ovf_cnt, 0);
    check("coin_q_one_left", exp_q.size(), 1);
    rx_ready = 1'b1;
    step(3);
    check("coin_drained", exp_q.size(), 0);
    check("coin_valid_low", {31'h0, rx_valid}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
